// File: rtl/mag_sqrt_ctrl.sv
// mag_sqrt_ctrl: sequential magnitude unit, y = floor(sqrt(a^2 + b^2)).
// Squares each operand with a shift-add loop, then hands the sum to an
// external `sqrt` block over its start/busy handshake and returns the root.
// Optional build macro MAG_SQRT_SUMSQ_OUT_EN adds sumsq_b/sumsq_vld outputs
// that expose the radicand once it is issued.
module mag_sqrt_ctrl #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a_b,
    input  logic [W-1:0]   b_b,
    output logic           busy,
    output logic [8:0]     y_b,
    output logic [23:0]    sq_x_b,
    output logic           sq_start,
    input  logic           sq_busy,
    input  logic [8:0]     sq_y_b
`ifdef MAG_SQRT_SUMSQ_OUT_EN
    ,
    output logic [2*W:0]   sumsq_b,
    output logic           sumsq_vld
`endif
);

    localparam int ACC_W = 2 * W + 1;
    localparam int CNT_W = $clog2(W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SQ_A = 3'd1;
    localparam logic [2:0] S_SQ_B = 3'd2;
    localparam logic [2:0] S_REQ  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_WAIT = 3'd5;

    logic [2:0]       state_q,    state_d;
    logic [W-1:0]     ra_q,       ra_d;
    logic [W-1:0]     rb_q,       rb_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             busy_q,     busy_d;
    logic [8:0]       y_q,        y_d;
    logic [23:0]      x_q,        x_d;
    logic             sq_start_q, sq_start_d;
`ifdef MAG_SQRT_SUMSQ_OUT_EN
    logic [ACC_W-1:0] sumsq_q,    sumsq_d;
    logic             sumsq_vld_q, sumsq_vld_d;
`endif

    logic [W-1:0]     op_sel;
    logic [ACC_W-1:0] addend;
    logic             cnt_last;

    // Partial product of the current squaring step: operand shifted by its bit index.
    assign op_sel   = (state_q == S_SQ_A) ? ra_q : rb_q;
    assign addend   = op_sel[cnt_q] ? (ACC_W'(op_sel) << cnt_q) : '0;
    assign cnt_last = (cnt_q == CNT_W'(W - 1));

    // Next-state and datapath update for the square/sum/request sequence.
    always_comb begin
        // NOTE: every _d takes its held value first, so no path through this block infers a latch.
        state_d    = state_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        y_d        = y_q;
        x_d        = x_q;
        sq_start_d = 1'b0;
`ifdef MAG_SQRT_SUMSQ_OUT_EN
        sumsq_d     = sumsq_q;
        sumsq_vld_d = sumsq_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d    = a_b;
                    rb_d    = b_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SQ_A;
`ifdef MAG_SQRT_SUMSQ_OUT_EN
                    sumsq_vld_d = 1'b0;
`endif
                end
            end
            S_SQ_A, S_SQ_B: begin
                acc_d = acc_q + addend;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_SQ_A) ? S_SQ_B : S_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                x_d        = 24'(acc_q);
                sq_start_d = 1'b1;
                state_d    = S_GAP;
`ifdef MAG_SQRT_SUMSQ_OUT_EN
                sumsq_d     = acc_q;
                sumsq_vld_d = 1'b1;
`endif
            end
            // sqrt raises its busy one cycle after seeing start; skip that cycle.
            S_GAP: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!sq_busy) begin
                    y_d     = sq_y_b;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) begin
            state_q    <= S_IDLE;
            ra_q       <= '0;
            rb_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            y_q        <= '0;
            x_q        <= '0;
            sq_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            y_q        <= y_d;
            x_q        <= x_d;
            sq_start_q <= sq_start_d;
        end
    end

`ifdef MAG_SQRT_SUMSQ_OUT_EN
    // Radicand observation registers, valid from REQ until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sumsq_q     <= '0;
            sumsq_vld_q <= 1'b0;
        end else begin
            sumsq_q     <= sumsq_d;
            sumsq_vld_q <= sumsq_vld_d;
        end
    end

    assign sumsq_b   = sumsq_q;
    assign sumsq_vld = sumsq_vld_q;
`endif

    assign busy     = busy_q;
    assign y_b      = y_q;
    assign sq_x_b   = x_q;
    assign sq_start = sq_start_q;

endmodule
